// File: rtl/float_sort_pkg.sv
// Shared types and constants for the float sorter and its triple packer.
package float_sort_pkg;

  // Float width shared with the sorter datapath (FP64).
  localparam int unsigned FLEN = 64;

  localparam logic [63:0] FP64_POS_INF = 64'h7FF0_0000_0000_0000;

  typedef enum logic {
    D_EMPTY,
    D_PENDING
  } disp_state_t;

  typedef logic [0:2][FLEN-1:0] triple_t;

endpackage

// File: rtl/float_triple_packer.sv
// Gathers a float stream into padded triples, hands each to the sorter when it
// is idle, and tags every sorted result with its count of real elements.
module float_triple_packer
  import float_sort_pkg::*;
#(
  parameter logic [FLEN-1:0] PAD_VALUE = FP64_POS_INF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [FLEN-1:0] in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            sort_valid_in,
  output triple_t         sort_unsorted,
  input  logic            sort_busy,
  input  logic            sort_valid_out,
  output logic [1:0]      res_count
);

  triple_t     slots_q, slots_d;
  logic [1:0]  fill_q, fill_d;
  logic        asm_full_q, asm_full_d;
  triple_t     disp_q, disp_d;
  logic [1:0]  disp_cnt_q, disp_cnt_d;
  logic [1:0]  inflight_cnt_q, inflight_cnt_d;
  disp_state_t disp_state_q, disp_state_d;

  logic        accept;
  logic        closing;
  logic        sorter_take;
  logic        disp_free;
  logic        transfer;
  triple_t     asm_next;
  logic [1:0]  asm_cnt;

  assign in_ready    = ~asm_full_q;
  assign accept      = in_valid & in_ready;
  assign closing     = accept & (in_last | (fill_q == 2'd2));
  assign sorter_take = (disp_state_q == D_PENDING) & ~sort_busy;
  assign disp_free   = (disp_state_q == D_EMPTY) | sorter_take;
  // A stalled group (asm_full) moves as soon as the dispatch register frees up.
  assign transfer    = (closing | asm_full_q) & disp_free;

  // Assembly contents including the beat accepted this cycle.
  always_comb begin
    asm_next = slots_q;
    if (accept) begin
      asm_next[fill_q] = in_data;
    end
    asm_cnt = fill_q + {1'b0, accept};
  end

  always_comb begin
    slots_d        = slots_q;
    fill_d         = fill_q;
    asm_full_d     = asm_full_q;
    disp_d         = disp_q;
    disp_cnt_d     = disp_cnt_q;
    inflight_cnt_d = inflight_cnt_q;
    disp_state_d   = disp_state_q;
    sort_valid_in  = 1'b0;

    if (transfer) begin
      for (int unsigned i = 0; i < 3; i++) begin
        disp_d[i] = (i < 32'(asm_cnt)) ? asm_next[i] : PAD_VALUE;
      end
      disp_cnt_d = asm_cnt;
      fill_d     = 2'd0;
      asm_full_d = 1'b0;
    end else if (closing) begin
      slots_d    = asm_next;
      fill_d     = asm_cnt;
      asm_full_d = 1'b1;
    end else if (accept) begin
      slots_d = asm_next;
      fill_d  = asm_cnt;
    end

    unique case (disp_state_q)
      D_EMPTY: begin
        if (transfer) begin
          disp_state_d = D_PENDING;
        end
      end
      D_PENDING: begin
        sort_valid_in = ~sort_busy;
        if (!sort_busy) begin
          inflight_cnt_d = disp_cnt_q;
          disp_state_d   = transfer ? D_PENDING : D_EMPTY;
        end
      end
      default: disp_state_d = D_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q        <= '0;
      fill_q         <= 2'd0;
      asm_full_q     <= 1'b0;
      disp_q         <= '0;
      disp_cnt_q     <= 2'd0;
      inflight_cnt_q <= 2'd0;
      disp_state_q   <= D_EMPTY;
    end else begin
      slots_q        <= slots_d;
      fill_q         <= fill_d;
      asm_full_q     <= asm_full_d;
      disp_q         <= disp_d;
      disp_cnt_q     <= disp_cnt_d;
      inflight_cnt_q <= inflight_cnt_d;
      disp_state_q   <= disp_state_d;
    end
  end

  assign sort_unsorted = disp_q;
  // The sorter holds one group at a time, so the last dispatched count tags its result.
  assign res_count     = sort_valid_out ? inflight_cnt_q : 2'd0;

endmodule

// File: tb/tb_float_triple_packer.sv
// Scoreboard bench for float_triple_packer with a behavioural 4-cycle sorter model.
module tb_float_triple_packer;
  import float_sort_pkg::*;

  localparam logic [63:0] INF = 64'h7FF0_0000_0000_0000;

  typedef struct {
    triple_t    v;
    logic [1:0] cnt;
  } grp_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [63:0]     in_data;
  logic            in_last;
  logic            in_ready;
  logic            sort_valid_in;
  triple_t         sort_unsorted;
  logic            sort_busy;
  logic            sort_valid_out;
  logic [1:0]      res_count;

  logic [1:0]      sorter_cnt;
  logic            hold_busy;

  int checks;
  int errors;
  int pulses;
  int ready_low;
  bit track_ready;

  grp_t        exp_q[$];
  logic [1:0]  infl_q[$];
  logic [63:0] acc[$];

  float_triple_packer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .sort_valid_in (sort_valid_in),
    .sort_unsorted (sort_unsorted),
    .sort_busy     (sort_busy),
    .sort_valid_out(sort_valid_out),
    .res_count     (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sorter: takes a group on valid_in, busy for 3 cycles, result on the third.
  always @(posedge clk) begin
    if (rst) sorter_cnt <= 2'd0;
    else if (sort_valid_in) sorter_cnt <= 2'd3;
    else if (sorter_cnt != 2'd0) sorter_cnt <= sorter_cnt - 2'd1;
  end
  assign sort_busy      = (sorter_cnt != 2'd0) | hold_busy;
  assign sort_valid_out = (sorter_cnt == 2'd1);

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Reference grouping: up to three beats, closed early by last, padded with +Inf.
  task automatic model_accept(input logic [63:0] d, input bit last);
    grp_t g;
    acc.push_back(d);
    if (last || acc.size() == 3) begin
      g.cnt = 2'(acc.size());
      for (int i = 0; i < 3; i++) g.v[i] = (i < acc.size()) ? acc[i] : INF;
      exp_q.push_back(g);
      acc.delete();
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input bit last);
    int  n;
    bit  done;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    done = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, last);
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout got in_ready=0 want 1");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || infl_q.size() != 0 || sort_busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size() + infl_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string name, input logic [1:0] cnt, input triple_t want);
    @(negedge clk);
    chk({name, "_valid_in"}, 192'(sort_valid_in), 192'(1'b1));
    chk({name, "_unsorted"}, want, want == sort_unsorted ? want : sort_unsorted);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_valid_out"}, 192'(sort_valid_out), 192'(1'b1));
    chk({name, "_res_count"}, 192'(res_count), 192'(cnt));
    @(posedge clk);
    #1;
  endtask

  // Monitor: every dispatch and every result is matched against the scoreboard.
  always @(negedge clk) begin
    grp_t       g;
    logic [1:0] c;
    if (!rst) begin
      if (sort_valid_in) begin
        pulses++;
        chk("valid_in_while_busy", 192'(sort_busy), 192'(1'b0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dispatch got %h want none", sort_unsorted);
        end else begin
          g = exp_q.pop_front();
          chk("dispatch_data", sort_unsorted, g.v);
          infl_q.push_back(g.cnt);
        end
      end
      if (sort_valid_out) begin
        if (infl_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got res_count=%0d want none", res_count);
        end else begin
          c = infl_q.pop_front();
          chk("res_count", 192'(res_count), 192'(c));
        end
      end else begin
        chk("res_count_idle", 192'(res_count), 192'(2'd0));
      end
      if (track_ready && !in_ready) ready_low++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    triple_t w;
    logic [63:0] d;
    checks = 0;
    errors = 0;
    pulses = 0;
    ready_low = 0;
    track_ready = 0;
    hold_busy = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid_in", 192'(sort_valid_in), 192'(1'b0));
    chk("reset_unsorted", sort_unsorted, 192'(0));
    chk("reset_res_count", 192'(res_count), 192'(2'd0));
    chk("reset_in_ready", 192'(in_ready), 192'(1'b1));
    @(posedge clk);
    #1;

    // Full triple
    send_beat(64'h4008_0000_0000_0000, 0);
    send_beat(64'h3FF0_0000_0000_0000, 0);
    send_beat(64'h4000_0000_0000_0000, 1);
    w[0] = 64'h4008_0000_0000_0000;
    w[1] = 64'h3FF0_0000_0000_0000;
    w[2] = 64'h4000_0000_0000_0000;
    check_latency("full", 2'd3, w);
    drain();

    // Short group
    send_beat(64'h4014_0000_0000_0000, 0);
    send_beat(64'h4010_0000_0000_0000, 1);
    w[0] = 64'h4014_0000_0000_0000;
    w[1] = 64'h4010_0000_0000_0000;
    w[2] = INF;
    check_latency("short", 2'd2, w);
    drain();

    // Single element
    send_beat(64'h3FF0_0000_0000_0000, 1);
    w[0] = 64'h3FF0_0000_0000_0000;
    w[1] = INF;
    w[2] = INF;
    check_latency("single", 2'd1, w);
    drain();

    // Back-to-back stream against a sorter that starts out busy
    pulses = 0;
    ready_low = 0;
    track_ready = 1;
    fork
      begin
        hold_busy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        hold_busy = 1'b0;
      end
      begin
        for (int i = 0; i < 9; i++) send_beat(64'h4020_0000_0000_0000 + 64'(i), 0);
      end
    join
    drain();
    track_ready = 0;
    chk("stream_pulses", 192'(pulses), 192'(3));
    chk("stream_in_ready_stall", 192'(ready_low > 0), 192'(1'b1));

    // Sorter held busy with a group pending
    hold_busy = 1'b1;
    send_beat(64'h3FF8_0000_0000_0000, 1);
    w[0] = 64'h3FF8_0000_0000_0000;
    w[1] = INF;
    w[2] = INF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid_in", 192'(sort_valid_in), 192'(1'b0));
      chk("hold_unsorted", sort_unsorted, w);
      @(posedge clk);
      #1;
    end
    hold_busy = 1'b0;
    @(negedge clk);
    chk("hold_release_dispatch", 192'(sort_valid_in), 192'(1'b1));
    @(posedge clk);
    #1;
    drain();

    // Reset mid-group discards the partial beats
    send_beat(64'h4022_0000_0000_0000, 0);
    send_beat(64'h4024_0000_0000_0000, 0);
    rst = 1'b1;
    acc.delete();
    exp_q.delete();
    infl_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_fill", 192'(dut.fill_q), 192'(2'd0));
    chk("midreset_in_ready", 192'(in_ready), 192'(1'b1));
    @(posedge clk);
    #1;
    send_beat(64'h4026_0000_0000_0000, 0);
    send_beat(64'h4028_0000_0000_0000, 0);
    send_beat(64'h402A_0000_0000_0000, 0);
    w[0] = 64'h4026_0000_0000_0000;
    w[1] = 64'h4028_0000_0000_0000;
    w[2] = 64'h402A_0000_0000_0000;
    check_latency("after_reset", 2'd3, w);
    drain();

    // Random stream with gaps and random early closes
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      d = {$urandom(), $urandom()};
      send_beat(d, $urandom_range(0, 3) == 0);
    end
    if (acc.size() != 0) send_beat({$urandom(), $urandom()}, 1);
    drain();
    chk("scoreboard_empty", 192'(exp_q.size() + infl_q.size()), 192'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
